// File: rtl/xge_mac_stats_reg_block.sv
// ---------------------------------------------------------------------------
// xge_mac_stats_reg_block
//
// Statistics register block for the XGE MAC. It holds NUM_CNT counters that
// the datapath increments, plus a CONFIG register and sticky overflow status.
// Software reaches them through a register port: one request cycle in, then a
// registered ack/rdata one cycle later.
//
// Register map (byte addresses, word aligned):
//   0x00 CONFIG   RW  [0] CNT_EN, [1] COR_EN, [2] SAT_MODE (reset 0x5)
//   0x04 CLEAR    WO  a 1 in bit i zeroes counter i; reads 0
//   0x08 OVF      W1C sticky overflow flag per counter
//   0x0C OVF_MASK RW  interrupt mask (only with XGE_MAC_STATS_IRQ_EN)
//   0x10+4*i      RW  counter i
//
// Ports:
//   clk, reset     clock and asynchronous active-high reset
//   regb_addr_i    byte address of the access
//   regb_wbdata_i  write data
//   regb_wen_i     write request (one cycle per access)
//   regb_ren_i     read request (one cycle per access)
//   regb_rdata_o   registered read data
//   regb_ack_o     access response, one cycle after the request
//   error_o        access error, qualified by regb_ack_o
//   cnt_inc_i      per-channel increment strobe
//   irq_o          overflow interrupt (only with XGE_MAC_STATS_IRQ_EN)
//
// Optional feature macro: XGE_MAC_STATS_IRQ_EN adds OVF_MASK and irq_o.
// ---------------------------------------------------------------------------
module xge_mac_stats_reg_block #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 32,
    parameter int NUM_CNT        = 4,
    parameter int CNT_WIDTH      = 32
) (
`ifdef XGE_MAC_STATS_IRQ_EN
    output logic                      irq_o,
`endif
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] regb_addr_i,
    input  logic [REG_DATA_WIDTH-1:0] regb_wbdata_i,
    input  logic                      regb_wen_i,
    input  logic                      regb_ren_i,
    output logic [REG_DATA_WIDTH-1:0] regb_rdata_o,
    output logic                      regb_ack_o,
    output logic                      error_o,
    input  logic [NUM_CNT-1:0]        cnt_inc_i
);

    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_CONFIG = REG_ADDR_WIDTH'(32'h0);
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_CLEAR  = REG_ADDR_WIDTH'(32'h4);
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_OVF    = REG_ADDR_WIDTH'(32'h8);
`ifdef XGE_MAC_STATS_IRQ_EN
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_MASK   = REG_ADDR_WIDTH'(32'hC);
`endif
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESP,
        ST_ERR
    } state_t;

    state_t                      state_q, state_d;
    logic [REG_DATA_WIDTH-1:0]   rdata_q;
    logic [2:0]                  cfg_q;
    logic [NUM_CNT-1:0]          ovf_q, ovf_d, ovf_set;
    logic [CNT_WIDTH-1:0]        cnt_q [NUM_CNT];
    logic [CNT_WIDTH-1:0]        cnt_d [NUM_CNT];

    logic                        hit_config, hit_clear, hit_ovf, hit_mask;
    logic [NUM_CNT-1:0]          hit_cnt;
    logic                        mapped, acc_err, wr_ok, rd_ok;
    logic                        cnt_en, cor_en, sat_mode;
    logic [NUM_CNT-1:0]          clr_vec, inc_vec, w1c_vec;
    logic [REG_DATA_WIDTH-1:0]   rd_val;

`ifdef XGE_MAC_STATS_IRQ_EN
    logic [NUM_CNT-1:0]          mask_q;
    logic                        irq_q;
`endif

    assign cnt_en   = cfg_q[0];
    assign cor_en   = cfg_q[1];
    assign sat_mode = cfg_q[2];

    // Exact full-width address compares; an unaligned address never matches
    // and therefore falls into the error path.
    assign hit_config = (regb_addr_i == ADDR_CONFIG);
    assign hit_clear  = (regb_addr_i == ADDR_CLEAR);
    assign hit_ovf    = (regb_addr_i == ADDR_OVF);
`ifdef XGE_MAC_STATS_IRQ_EN
    assign hit_mask   = (regb_addr_i == ADDR_MASK);
`else
    assign hit_mask   = 1'b0;
`endif

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt_hit
        assign hit_cnt[g] = (regb_addr_i == REG_ADDR_WIDTH'(32'h10 + 4 * g));
    end

    // Simultaneous read+write, or any access outside the map, is answered
    // with an error and must not touch any state.
    assign mapped  = hit_config | hit_clear | hit_ovf | hit_mask | (|hit_cnt);
    assign acc_err = (regb_wen_i & regb_ren_i) |
                     ((regb_wen_i | regb_ren_i) & ~mapped);
    assign wr_ok   = regb_wen_i & ~regb_ren_i & mapped;
    assign rd_ok   = regb_ren_i & ~regb_wen_i & mapped;

    assign clr_vec = ((wr_ok && hit_clear) ? regb_wbdata_i[NUM_CNT-1:0] : '0) |
                     ((rd_ok && cor_en) ? hit_cnt : '0);
    assign inc_vec = cnt_inc_i & {NUM_CNT{cnt_en}};
    assign w1c_vec = (wr_ok && hit_ovf) ? regb_wbdata_i[NUM_CNT-1:0] : '0;

    // Per-channel next value: a register write wins over a clear, which wins
    // over an increment. A clear coinciding with an increment leaves 1, since
    // the event happened after the counter was zeroed.
    always_comb begin
        ovf_set = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (wr_ok && hit_cnt[i]) begin
                cnt_d[i] = regb_wbdata_i[CNT_WIDTH-1:0];
            end else if (clr_vec[i]) begin
                cnt_d[i] = inc_vec[i] ? CNT_ONE : '0;
            end else if (inc_vec[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_set[i] = 1'b1;
                    if (!sat_mode) begin
                        cnt_d[i] = '0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // A new overflow in the same cycle as a software W1C keeps the flag set.
    assign ovf_d = (ovf_q & ~w1c_vec) | ovf_set;

    // Read mux; the counter value returned is the pre-clear value, so a
    // clear-on-read never loses the count being reported.
    always_comb begin
        rd_val = '0;
        if (hit_config) begin
            rd_val[2:0] = cfg_q;
        end else if (hit_ovf) begin
            rd_val[NUM_CNT-1:0] = ovf_q;
`ifdef XGE_MAC_STATS_IRQ_EN
        end else if (hit_mask) begin
            rd_val[NUM_CNT-1:0] = mask_q;
`endif
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (hit_cnt[i]) begin
                    rd_val[CNT_WIDTH-1:0] = cnt_q[i];
                end
            end
        end
    end

    // Response FSM: every request cycle produces exactly one response cycle,
    // so back-to-back requests keep ack high continuously.
    always_comb begin
        state_d = ST_IDLE;
        if (acc_err) begin
            state_d = ST_ERR;
        end else if (regb_wen_i || regb_ren_i) begin
            state_d = ST_RESP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            cfg_q   <= 3'b101;
            ovf_q   <= '0;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            rdata_q <= rd_ok ? rd_val : '0;
            if (wr_ok && hit_config) begin
                cfg_q <= regb_wbdata_i[2:0];
            end
            ovf_q <= ovf_d;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef XGE_MAC_STATS_IRQ_EN
    // Interrupt is registered from the stored flags, so it follows an OVF or
    // mask change by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_ok && hit_mask) begin
                mask_q <= regb_wbdata_i[NUM_CNT-1:0];
            end
            irq_q <= |(ovf_q & mask_q);
        end
    end

    assign irq_o = irq_q;
`endif

    assign regb_ack_o   = (state_q != ST_IDLE);
    assign error_o      = (state_q == ST_ERR);
    assign regb_rdata_o = rdata_q;

endmodule

// File: tb/tb_xge_mac_stats_reg_block.sv
// ---------------------------------------------------------------------------
// tb_xge_mac_stats_reg_block
//
// Bench for xge_mac_stats_reg_block with default parameters (4 channels,
// 32-bit counters). A table of register accesses is applied one per cycle;
// the expected response of each access is queued when it is driven and
// compared one cycle later. Reset-during-access and the interrupt timing are
// written out by hand. Define XGE_MAC_STATS_IRQ_EN to build the IRQ variant.
// ---------------------------------------------------------------------------
module tb_xge_mac_stats_reg_block;

`ifdef XGE_MAC_STATS_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic        ren;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic [3:0]  inc;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit          wen;
        bit          ren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  inc;
        bit          exp_err;
        bit          chk;
        logic [31:0] exp_rdata;
        string       name;
    } vec_t;

    typedef struct {
        bit          ack;
        bit          err;
        bit          chk;
        logic [31:0] rdata;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t expQ[$];

    xge_mac_stats_reg_block dut (
`ifdef XGE_MAC_STATS_IRQ_EN
        .irq_o         (irq),
`endif
        .clk           (clk),
        .reset         (reset),
        .regb_addr_i   (addr),
        .regb_wbdata_i (wdata),
        .regb_wen_i    (wen),
        .regb_ren_i    (ren),
        .regb_rdata_o  (rdata),
        .regb_ack_o    (ack),
        .error_o       (err),
        .cnt_inc_i     (inc)
    );

`ifndef XGE_MAC_STATS_IRQ_EN
    assign irq = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    function automatic void addVec(input bit w, input bit r, input logic [31:0] a,
                                   input logic [31:0] d, input logic [3:0] i,
                                   input bit e, input bit c, input logic [31:0] x,
                                   input string n);
        vec_t v;
        v.wen = w; v.ren = r; v.addr = a; v.wdata = d; v.inc = i;
        v.exp_err = e; v.chk = c; v.exp_rdata = x; v.name = n;
        vecs.push_back(v);
    endfunction

    function automatic void rdV(input logic [31:0] a, input logic [31:0] x, input string n);
        addVec(1'b0, 1'b1, a, 32'h0, 4'h0, 1'b0, 1'b1, x, n);
    endfunction

    function automatic void wrV(input logic [31:0] a, input logic [31:0] d, input string n);
        addVec(1'b1, 1'b0, a, d, 4'h0, 1'b0, 1'b0, 32'h0, n);
    endfunction

    function automatic void idleV(input logic [3:0] i, input string n);
        addVec(1'b0, 1'b0, 32'h0, 32'h0, i, 1'b0, 1'b0, 32'h0, n);
    endfunction

    function automatic void errV(input bit w, input bit r, input logic [31:0] a,
                                 input logic [31:0] d, input string n);
        addVec(w, r, a, d, 4'h0, 1'b1, 1'b1, 32'h0, n);
    endfunction

    // Pops the response owed for the request of the previous cycle.
    task automatic checkOutput();
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            cmp({e.name, ".ack"}, {31'h0, ack}, {31'h0, e.ack});
            cmp({e.name, ".error"}, {31'h0, err}, {31'h0, e.err});
            if (e.chk) begin
                cmp({e.name, ".rdata"}, rdata, e.rdata);
            end
        end
    endtask

    // At the falling edge: check last cycle's response, then drive this one.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(negedge clk);
        checkOutput();
        wen   = v.wen;
        ren   = v.ren;
        addr  = v.addr;
        wdata = v.wdata;
        inc   = v.inc;
        e.ack   = v.wen | v.ren;
        e.err   = v.exp_err;
        e.chk   = v.chk;
        e.rdata = v.exp_rdata;
        e.name  = v.name;
        expQ.push_back(e);
    endtask

    task automatic idleCycle();
        vec_t v;
        v.wen = 1'b0; v.ren = 1'b0; v.addr = 32'h0; v.wdata = 32'h0; v.inc = 4'h0;
        v.exp_err = 1'b0; v.chk = 1'b0; v.exp_rdata = 32'h0; v.name = "idle";
        applyStimulus(v);
    endtask

    initial begin
        reset = 1'b1; wen = 1'b0; ren = 1'b0; addr = '0; wdata = '0; inc = '0;

        // Main table, applied back to back (one access per cycle).
        rdV  (32'h00, 32'h5, "cfg_reset");
        rdV  (32'h10, 32'h0, "cnt0_reset");
        idleV(4'b0010, "inc1_a");
        idleV(4'b0010, "inc1_b");
        idleV(4'b0010, "inc1_c");
        rdV  (32'h14, 32'h3, "cnt1_three");
        wrV  (32'h00, 32'h4, "cfg_disable");
        idleV(4'b0010, "inc1_ignored_a");
        idleV(4'b0010, "inc1_ignored_b");
        rdV  (32'h14, 32'h3, "cnt1_still_three");
        rdV  (32'h00, 32'h4, "cfg_readback");
        wrV  (32'h00, 32'h1, "cfg_wrap");
        wrV  (32'h10, 32'hFFFF_FFFF, "cnt0_max_wrap");
        idleV(4'b0001, "inc0_wrap");
        rdV  (32'h10, 32'h0, "cnt0_wrapped");
        rdV  (32'h08, 32'h1, "ovf_after_wrap");
        wrV  (32'h00, 32'h5, "cfg_sat");
        wrV  (32'h10, 32'hFFFF_FFFF, "cnt0_max_sat");
        idleV(4'b0001, "inc0_sat");
        rdV  (32'h10, 32'hFFFF_FFFF, "cnt0_saturated");
        rdV  (32'h08, 32'h1, "ovf_after_sat");
        wrV  (32'h08, 32'h1, "ovf_w1c");
        rdV  (32'h08, 32'h0, "ovf_cleared");
        wrV  (32'h1C, 32'h55, "cnt3_write");
        rdV  (32'h1C, 32'h55, "cnt3_write_visible");
        wrV  (32'h00, 32'h7, "cfg_cor");
        wrV  (32'h18, 32'h7, "cnt2_seven");
        addVec(1'b0, 1'b1, 32'h18, 32'h0, 4'b0100, 1'b0, 1'b1, 32'h7, "cor_read_inc");
        rdV  (32'h18, 32'h1, "cor_after_inc");
        rdV  (32'h18, 32'h0, "cor_after_clear");
        addVec(1'b1, 1'b0, 32'h14, 32'h10, 4'b0010, 1'b0, 1'b0, 32'h0, "cnt1_write_inc");
        rdV  (32'h14, 32'h10, "write_beats_inc");
        addVec(1'b1, 1'b0, 32'h04, 32'h8, 4'b1000, 1'b0, 1'b0, 32'h0, "clear3_inc");
        wrV  (32'h00, 32'h5, "cfg_no_cor");
        rdV  (32'h1C, 32'h1, "clear_inc_is_one");
        rdV  (32'h04, 32'h0, "clear_reads_zero");
        wrV  (32'h04, 32'h8, "clear3");
        rdV  (32'h1C, 32'h0, "cnt3_cleared");
        errV (1'b1, 1'b1, 32'h00, 32'h0, "err_wen_ren");
        rdV  (32'h00, 32'h5, "cfg_unchanged_a");
        errV (1'b0, 1'b1, 32'h20, 32'h0, "err_cnt_range");
        errV (1'b0, 1'b1, 32'h02, 32'h0, "err_unaligned");
        if (IRQ_BUILD) rdV(32'h0C, 32'h0, "mask_read");
        else           errV(1'b0, 1'b1, 32'h0C, 32'h0, "err_mask_absent");
        errV (1'b1, 1'b0, 32'h01, 32'h0, "err_wr_unaligned");
        rdV  (32'h00, 32'h5, "cfg_unchanged_b");
        errV (1'b1, 1'b0, 32'h20, 32'h1, "err_wr_range");
        rdV  (32'h10, 32'hFFFF_FFFF, "cnt0_unchanged");
        idleV(4'b0001, "inc0_ovf_again");
        addVec(1'b1, 1'b0, 32'h08, 32'h1, 4'b0001, 1'b0, 1'b0, 32'h0, "w1c_with_ovf");
        rdV  (32'h08, 32'h1, "set_beats_w1c");
        wrV  (32'h08, 32'h1, "ovf_w1c_again");
        rdV  (32'h08, 32'h0, "ovf_cleared_again");

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cmp("reset.ack", {31'h0, ack}, 32'h0);
        cmp("reset.error", {31'h0, err}, 32'h0);
        cmp("reset.rdata", rdata, 32'h0);
        cmp("reset.irq", {31'h0, irq}, 32'h0);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k]);
        end
        idleCycle();
        @(negedge clk);
        checkOutput();

        // Reset in the middle of an access: the pending ack must vanish.
        wen = 1'b0; ren = 1'b1; addr = 32'h0; inc = '0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        cmp("midreset.ack", {31'h0, ack}, 32'h0);
        cmp("midreset.error", {31'h0, err}, 32'h0);
        cmp("midreset.rdata", rdata, 32'h0);
        @(negedge clk);
        ren = 1'b0;
        reset = 1'b0;
        expQ.delete();
        vecs.delete();
        rdV(32'h10, 32'h0, "cnt0_after_reset");
        rdV(32'h08, 32'h0, "ovf_after_reset");
        rdV(32'h00, 32'h5, "cfg_after_reset");
        foreach (vecs[k]) begin
            applyStimulus(vecs[k]);
        end
        idleCycle();

`ifdef XGE_MAC_STATS_IRQ_EN
        // Interrupt rises one cycle after the flag sets, falls one after W1C.
        vecs.delete();
        wrV  (32'h0C, 32'h1, "mask_set");
        wrV  (32'h10, 32'hFFFF_FFFF, "cnt0_max_irq");
        idleV(4'b0001, "inc0_irq");
        idleV(4'b0000, "irq_wait");
        wrV  (32'h08, 32'h1, "irq_w1c");
        idleV(4'b0000, "irq_fall");
        idleV(4'b0000, "irq_low");
        applyStimulus(vecs[0]);
        applyStimulus(vecs[1]);
        applyStimulus(vecs[2]);
        applyStimulus(vecs[3]);
        cmp("irq_not_yet", {31'h0, irq}, 32'h0);
        applyStimulus(vecs[4]);
        cmp("irq_high", {31'h0, irq}, 32'h1);
        applyStimulus(vecs[5]);
        cmp("irq_held_on_w1c", {31'h0, irq}, 32'h1);
        applyStimulus(vecs[6]);
        cmp("irq_low", {31'h0, irq}, 32'h0);
`endif

        @(negedge clk);
        checkOutput();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
